// File: rtl/mem_stage_pipe.sv
// Registered memory stage between execute and writeback: drives a valid/ready
// data-memory handshake, stalls upstream during accesses, resolves branches and times out hung accesses.
module mem_stage_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      iClk,
  input  logic                      iReset_n,
  input  logic                      iValid,
  input  logic [DATA_WIDTH-1:0]     iExuResult,
  input  logic [DATA_WIDTH-1:0]     iMemData,
  input  logic                      iMemRead,
  input  logic                      iMemWrite,
  input  logic [ADDR_WIDTH-1:0]     iNextPC,
  input  logic [ADDR_WIDTH-1:0]     iBranchAddr,
  input  logic                      iBranchCmd,
  input  logic [2:0]                iBranchOp,
  input  logic                      iBranchPredict,
  input  logic                      iZeroFlag,
  input  logic                      iNegativeFlag,
  input  logic                      iOverflowFlag,
  input  logic [REG_ADDR_WIDTH-1:0] iWriteAddr,
  input  logic                      iWriteEn,
  input  logic [DATA_WIDTH-1:0]     iDataMemData,
  input  logic                      iDataMemReady,
  output logic                      oStall,
  output logic                      oDataMemValid,
  output logic                      oDataMemRW,
  output logic [ADDR_WIDTH-1:0]     oDataMemAddr,
  output logic [DATA_WIDTH-1:0]     oDataMemData,
  output logic                      oValid,
  output logic [DATA_WIDTH-1:0]     oMemData,
  output logic [DATA_WIDTH-1:0]     oExuData,
  output logic [REG_ADDR_WIDTH-1:0] oWriteAddr,
  output logic                      oWriteEn,
  output logic                      oMemToReg,
  output logic                      oBranchMissCmd,
  output logic [ADDR_WIDTH-1:0]     oBranchMissAddr,
  output logic                      oMemError
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } stateT;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  stateT                     state;
  logic [7:0]                timeoutCnt;
  logic                      branchTaken;
  logic                      branchMiss;
  logic [ADDR_WIDTH-1:0]     branchMissAddr;
  logic                      isMemOp;

  // Bundle captured at accept and released when a memory access finishes
  logic [DATA_WIDTH-1:0]     pendExuData;
  logic [REG_ADDR_WIDTH-1:0] pendWriteAddr;
  logic                      pendWriteEn;
  logic                      pendMemToReg;
  logic                      pendBranchMiss;
  logic [ADDR_WIDTH-1:0]     pendBranchMissAddr;

  assign oStall        = (state == WAIT);
  assign oDataMemValid = (state == WAIT);
  assign isMemOp       = iMemRead | iMemWrite;

  always_comb begin
    branchTaken = 1'b0;
    if (iBranchCmd) begin
      case (iBranchOp)
        3'b000:  branchTaken = iZeroFlag;
        3'b001:  branchTaken = ~iZeroFlag;
        3'b010:  branchTaken = iNegativeFlag ^ iOverflowFlag;
        3'b011:  branchTaken = ~(iNegativeFlag ^ iOverflowFlag);
        3'b100:  branchTaken = 1'b1;
        default: branchTaken = 1'b0;
      endcase
    end
    branchMiss     = branchTaken ^ iBranchPredict;
    branchMissAddr = iBranchPredict ? iNextPC : iBranchAddr;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state              <= IDLE;
      timeoutCnt         <= '0;
      oDataMemRW         <= 1'b0;
      oDataMemAddr       <= '0;
      oDataMemData       <= '0;
      oValid             <= 1'b0;
      oMemData           <= '0;
      oExuData           <= '0;
      oWriteAddr         <= '0;
      oWriteEn           <= 1'b0;
      oMemToReg          <= 1'b0;
      oBranchMissCmd     <= 1'b0;
      oBranchMissAddr    <= '0;
      oMemError          <= 1'b0;
      pendExuData        <= '0;
      pendWriteAddr      <= '0;
      pendWriteEn        <= 1'b0;
      pendMemToReg       <= 1'b0;
      pendBranchMiss     <= 1'b0;
      pendBranchMissAddr <= '0;
    end else begin
      oValid         <= 1'b0;
      oBranchMissCmd <= 1'b0;
      oMemError      <= 1'b0;
      case (state)
        IDLE: begin
          if (iValid) begin
            if (isMemOp) begin
              state              <= WAIT;
              timeoutCnt         <= '0;
              oDataMemRW         <= iMemWrite;
              oDataMemAddr       <= iExuResult[ADDR_WIDTH-1:0];
              oDataMemData       <= iMemData;
              pendExuData        <= iExuResult;
              pendWriteAddr      <= iWriteAddr;
              pendWriteEn        <= iWriteEn;
              pendMemToReg       <= iMemRead;
              pendBranchMiss     <= branchMiss;
              pendBranchMissAddr <= branchMissAddr;
            end else begin
              oValid          <= 1'b1;
              oExuData        <= iExuResult;
              oWriteAddr      <= iWriteAddr;
              oWriteEn        <= iWriteEn;
              oMemToReg       <= 1'b0;
              oBranchMissCmd  <= branchMiss;
              oBranchMissAddr <= branchMissAddr;
            end
          end
        end
        WAIT: begin
          // Ready on the timeout edge still completes normally
          if (iDataMemReady) begin
            state           <= IDLE;
            oValid          <= 1'b1;
            oMemData        <= oDataMemRW ? '0 : iDataMemData;
            oExuData        <= pendExuData;
            oWriteAddr      <= pendWriteAddr;
            oWriteEn        <= pendWriteEn;
            oMemToReg       <= pendMemToReg;
            oBranchMissCmd  <= pendBranchMiss;
            oBranchMissAddr <= pendBranchMissAddr;
          end else if (timeoutCnt == TIMEOUT_LAST) begin
            state      <= IDLE;
            oValid     <= 1'b1;
            oMemError  <= 1'b1;
            oExuData   <= pendExuData;
            oWriteAddr <= pendWriteAddr;
            oWriteEn   <= 1'b0;
            oMemToReg  <= pendMemToReg;
          end else begin
            timeoutCnt <= timeoutCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
